// File: rtl/gx4000_pkg.sv
// Shared Plus-ASIC unlock constants and lock FSM encoding, used by the
// lock detector, the register page mapper and the bench.
package gx4000_pkg;

   localparam int SEQ_MAX = 30;

   localparam logic [7:0] UNLOCK_KEY = 8'hEE;

   // Entries at or beyond the instantiated SEQ_LEN are never addressed.
   localparam logic [7:0] UNLOCK_SEQ [SEQ_MAX] = '{
      8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62, 8'h39,
      8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      SYNC  = 2'd1,
      MATCH = 2'd2,
      KEY   = 2'd3
   } lock_state_t;

endpackage

// File: rtl/gx4000_asic_lock_if.sv
// CPU I/O write bus as seen by the ASIC lock detector.
// io_wr is a level strobe: each rising edge is one write, no ready/back-pressure.
interface gx4000_asic_lock_if;

   logic [15:0] io_addr;
   logic [7:0]  io_data;
   logic        io_wr;

   modport master (output io_addr, output io_data, output io_wr);
   modport slave  (input  io_addr, input  io_data, input  io_wr);

endinterface

// File: rtl/gx4000_io_wr_decode.sv
// Turns a level I/O write strobe into a single-cycle accept for the decoded port.
module gx4000_io_wr_decode #(
   parameter logic [15:0] ADDR_MASK  = 16'h4300,
   parameter logic [15:0] ADDR_MATCH = 16'h0000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [15:0] io_addr,
   input  logic [7:0]  io_data,
   input  logic        io_wr,
   output logic        wr_accept,
   output logic [7:0]  wr_data
);

   logic io_wr_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         io_wr_q <= 1'b0;
      end else begin
         io_wr_q <= io_wr;
      end
   end

   assign wr_accept = io_wr & ~io_wr_q & ((io_addr & ADDR_MASK) == ADDR_MATCH);
   assign wr_data   = io_data;

endmodule

// File: rtl/gx4000_asic_lock.sv
// Plus-ASIC lock detector: sync pair, fixed match bytes, then key byte
// gates the ASIC register page.
module gx4000_asic_lock
   import gx4000_pkg::*;
#(
   parameter int          SEQ_LEN      = 14,
   parameter logic [15:0] ADDR_MASK    = 16'h4300,
   parameter logic [15:0] ADDR_MATCH   = 16'h0000,
   parameter bit          ALLOW_RELOCK = 1'b1
) (
   input  logic                     clk_sys,
   input  logic                     reset,
   input  logic                     plus_mode,
   gx4000_asic_lock_if.slave        io,
   output logic                     unlocked,
   output logic                     unlock_pulse,
   output logic                     lock_pulse,
   output logic [4:0]               seq_pos,
   output logic [7:0]               status
);

   localparam logic [4:0] LAST_POS = 5'(SEQ_LEN - 1);

   logic        wr_accept;
   logic [7:0]  wr_data;

   lock_state_t state_q;
   logic [4:0]  seq_pos_q;
   logic        unlocked_q;
   logic        unlock_pulse_q;
   logic        lock_pulse_q;

   gx4000_io_wr_decode #(
      .ADDR_MASK  (ADDR_MASK),
      .ADDR_MATCH (ADDR_MATCH)
   ) u_decode (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .io_addr   (io.io_addr),
      .io_data   (io.io_data),
      .io_wr     (io.io_wr),
      .wr_accept (wr_accept),
      .wr_data   (wr_data)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q        <= HUNT;
         seq_pos_q      <= '0;
         unlocked_q     <= 1'b0;
         unlock_pulse_q <= 1'b0;
         lock_pulse_q   <= 1'b0;
      end else begin
         unlock_pulse_q <= 1'b0;
         lock_pulse_q   <= 1'b0;
         if (!plus_mode) begin
            state_q      <= HUNT;
            seq_pos_q    <= '0;
            unlocked_q   <= 1'b0;
            lock_pulse_q <= unlocked_q;
         end else if (wr_accept) begin
            case (state_q)
               HUNT: begin
                  if (wr_data != 8'h00) state_q <= SYNC;
               end
               SYNC: begin
                  if (wr_data == 8'h00) begin
                     state_q   <= MATCH;
                     seq_pos_q <= '0;
                  end
               end
               MATCH: begin
                  if (wr_data == UNLOCK_SEQ[seq_pos_q]) begin
                     if (seq_pos_q == LAST_POS) begin
                        state_q   <= KEY;
                        seq_pos_q <= '0;
                     end else begin
                        seq_pos_q <= seq_pos_q + 5'd1;
                     end
                  end else if (wr_data == 8'h00) begin
                     // A stray 00 is a fresh sync pair tail: restart matching.
                     seq_pos_q <= '0;
                  end else begin
                     state_q   <= SYNC;
                     seq_pos_q <= '0;
                  end
               end
               KEY: begin
                  if (wr_data == UNLOCK_KEY) begin
                     unlocked_q     <= 1'b1;
                     unlock_pulse_q <= ~unlocked_q;
                  end else if (ALLOW_RELOCK) begin
                     unlocked_q   <= 1'b0;
                     lock_pulse_q <= unlocked_q;
                  end
                  state_q <= (wr_data != 8'h00) ? SYNC : HUNT;
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign unlocked     = unlocked_q;
   assign unlock_pulse = unlock_pulse_q;
   assign lock_pulse   = lock_pulse_q;
   assign seq_pos      = seq_pos_q;
   assign status       = {unlocked_q, state_q, seq_pos_q};

endmodule

// File: tb/tb_gx4000_asic_lock.sv
// Directed bench for gx4000_asic_lock: stream-level model checked every cycle
// against a relocking and a sticky instance, plus literal spot checks.
module tb_gx4000_asic_lock;

   localparam int SEQ_N = 14;
   localparam logic [7:0] KEY_B = 8'hEE;

   logic clk_sys = 1'b0;
   logic reset;
   logic plus_mode;

   gx4000_asic_lock_if bus ();

   logic       unl_a, up_a, lp_a;
   logic [4:0] pos_a;
   logic [7:0] st_a;
   logic       unl_b, up_b, lp_b;
   logic [4:0] pos_b;
   logic [7:0] st_b;

   gx4000_asic_lock u_dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .plus_mode    (plus_mode),
      .io           (bus),
      .unlocked     (unl_a),
      .unlock_pulse (up_a),
      .lock_pulse   (lp_a),
      .seq_pos      (pos_a),
      .status       (st_a)
   );

   gx4000_asic_lock #(.ALLOW_RELOCK(1'b0)) u_dut_sticky (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .plus_mode    (plus_mode),
      .io           (bus),
      .unlocked     (unl_b),
      .unlock_pulse (up_b),
      .lock_pulse   (lp_b),
      .seq_pos      (pos_b),
      .status       (st_b)
   );

   always #5 clk_sys = ~clk_sys;

   logic [7:0] seq_tab [SEQ_N] = '{
      8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
      8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD
   };

   int n_checks = 0;
   int n_fail   = 0;
   int up_cnt_a = 0;
   int lp_cnt_a = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_prog is progress through the stream FF 00 SEQ KEY.
   // 0 = hunting, 1 = saw non-zero, 2..2+SEQ_N-1 = matching, 2+SEQ_N = awaiting key.
   int   m_prog = 0;
   logic m_prev = 1'b0;
   logic m_ua = 1'b0, m_upa = 1'b0, m_lpa = 1'b0;
   logic m_ub = 1'b0, m_upb = 1'b0, m_lpb = 1'b0;

   always @(posedge clk_sys) begin
      int p;
      logic [7:0] b;
      logic acc, ua, ub, upa, lpa, upb, lpb;
      p = m_prog; ua = m_ua; ub = m_ub;
      upa = 1'b0; lpa = 1'b0; upb = 1'b0; lpb = 1'b0;
      b = bus.io_data;
      acc = bus.io_wr && !m_prev && ((bus.io_addr & 16'h4300) == 16'h0000);
      if (reset) begin
         p = 0; ua = 1'b0; ub = 1'b0;
      end else if (!plus_mode) begin
         lpa = ua; lpb = ub; p = 0; ua = 1'b0; ub = 1'b0;
      end else if (acc) begin
         if (p == 0) begin
            p = (b != 8'h00) ? 1 : 0;
         end else if (p == 1) begin
            if (b == 8'h00) p = 2;
         end else if (p < 2 + SEQ_N) begin
            if (b == seq_tab[p-2]) p = p + 1;
            else if (b == 8'h00) p = 2;
            else p = 1;
         end else begin
            if (b == KEY_B) begin
               upa = !ua; upb = !ub; ua = 1'b1; ub = 1'b1;
            end else begin
               lpa = ua; ua = 1'b0;
            end
            p = (b != 8'h00) ? 1 : 0;
         end
      end
      m_prev <= reset ? 1'b0 : bus.io_wr;
      m_prog <= p;
      m_ua <= ua; m_upa <= upa; m_lpa <= lpa;
      m_ub <= ub; m_upb <= upb; m_lpb <= lpb;
   end

   function automatic logic [1:0] exp_state();
      if (m_prog < 2) return 2'(m_prog);
      if (m_prog < 2 + SEQ_N) return 2'd2;
      return 2'd3;
   endfunction

   function automatic logic [4:0] exp_pos();
      if (m_prog >= 2 && m_prog < 2 + SEQ_N) return 5'(m_prog - 2);
      return 5'd0;
   endfunction

   always @(negedge clk_sys) begin
      chk("unlocked_a", 8'(unl_a), 8'(m_ua));
      chk("unlock_pulse_a", 8'(up_a), 8'(m_upa));
      chk("lock_pulse_a", 8'(lp_a), 8'(m_lpa));
      chk("seq_pos_a", 8'(pos_a), 8'(exp_pos()));
      chk("status_a", st_a, {m_ua, exp_state(), exp_pos()});
      chk("unlocked_b", 8'(unl_b), 8'(m_ub));
      chk("unlock_pulse_b", 8'(up_b), 8'(m_upb));
      chk("lock_pulse_b", 8'(lp_b), 8'(m_lpb));
      chk("status_b", st_b, {m_ub, exp_state(), exp_pos()});
      if (up_a === 1'b1) up_cnt_a++;
      if (lp_a === 1'b1) lp_cnt_a++;
   end

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      @(posedge clk_sys); #1;
      bus.io_addr = a; bus.io_data = d; bus.io_wr = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1 bus.io_wr = 1'b0;
   endtask

   task automatic send_seq(input int from, input int to, input logic [15:0] a);
      for (int i = from; i <= to; i++) wr(a, seq_tab[i]);
   endtask

   task automatic send_full(input logic [15:0] a, input logic [7:0] key);
      wr(a, 8'hFF);
      wr(a, 8'h00);
      send_seq(0, SEQ_N - 1, a);
      wr(a, key);
   endtask

   task automatic send_interleaved();
      logic [7:0] s [$];
      s.push_back(8'hFF);
      s.push_back(8'h00);
      for (int i = 0; i < SEQ_N; i++) s.push_back(seq_tab[i]);
      s.push_back(KEY_B);
      foreach (s[i]) begin
         wr(16'hBD00, 8'h00);
         wr(16'h7F00, 8'h55);
         wr(16'hBC00, s[i]);
      end
   endtask

   task automatic do_reset();
      @(posedge clk_sys); #1 reset = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      chk("in_reset_unlocked", 8'(unl_a), 8'h00);
      chk("in_reset_status", st_a, 8'h00);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      plus_mode = 1'b1;
      bus.io_addr = 16'h0000;
      bus.io_data = 8'h00;
      bus.io_wr = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1 reset = 1'b0;
      chk("reset_status", st_a, 8'h00);
      chk("reset_unlocked", 8'(unl_a), 8'h00);

      // Full unlock sequence.
      up_cnt_a = 0;
      send_full(16'hBC00, KEY_B);
      chk("t1_unlocked", 8'(unl_a), 8'h01);
      chk("t1_status7", 8'(st_a[7]), 8'h01);
      chk("t1_pulse_count", 8'(up_cnt_a), 8'h01);

      // Wrong key (00) relocks A, sticky B stays unlocked; state back to HUNT.
      lp_cnt_a = 0;
      send_full(16'hBC00, 8'h00);
      chk("t2_unlocked_a", 8'(unl_a), 8'h00);
      chk("t2_lock_pulses", 8'(lp_cnt_a), 8'h01);
      chk("t2_unlocked_b", 8'(unl_b), 8'h01);
      chk("t2_status_a", st_a, 8'h00);

      // Break at position 6 by 00, then resync.
      do_reset();
      wr(16'hBC00, 8'hFF); wr(16'hBC00, 8'h00);
      send_seq(0, 5, 16'hBC00);
      chk("t3_pos6", 8'(pos_a), 8'h06);
      wr(16'hBC00, 8'h00);
      send_seq(0, SEQ_N - 1, 16'hBC00);
      wr(16'hBC00, KEY_B);
      chk("t3_resync_unlocked", 8'(unl_a), 8'h01);

      // Break by 55: back to SYNC, no unlock until a new 00.
      do_reset();
      wr(16'hBC00, 8'hFF); wr(16'hBC00, 8'h00);
      send_seq(0, 5, 16'hBC00);
      wr(16'hBC00, 8'h55);
      chk("t4_status_sync", st_a, 8'h20);
      send_seq(0, SEQ_N - 1, 16'hBC00);
      wr(16'hBC00, KEY_B);
      chk("t4_no_unlock_status", st_a, 8'h20);
      wr(16'hBC00, 8'h00);
      send_seq(0, SEQ_N - 1, 16'hBC00);
      wr(16'hBC00, KEY_B);
      chk("t4_unlock_after_sync", 8'(unl_a), 8'h01);

      // Reset after byte 10 aborts; the tail alone cannot unlock.
      do_reset();
      wr(16'hBC00, 8'hFF); wr(16'hBC00, 8'h00);
      send_seq(0, 7, 16'hBC00);
      chk("t5_pos8", 8'(pos_a), 8'h08);
      do_reset();
      chk("t5_after_reset_status", st_a, 8'h00);
      send_seq(8, SEQ_N - 1, 16'hBC00);
      wr(16'hBC00, KEY_B);
      chk("t5_tail_locked", 8'(unl_a), 8'h00);

      // Non-decoded ports are transparent; the same stream to &BD00 does nothing.
      do_reset();
      send_interleaved();
      chk("t6_interleaved_unlocked", 8'(unl_a), 8'h01);
      do_reset();
      send_full(16'hBD00, KEY_B);
      chk("t6_bd00_status", st_a, 8'h00);

      // plus_mode drop while unlocked, with a simultaneous accept.
      send_full(16'hBC00, KEY_B);
      chk("t7_unlocked", 8'(unl_a), 8'h01);
      lp_cnt_a = 0;
      @(posedge clk_sys); #1;
      plus_mode = 1'b0;
      bus.io_addr = 16'hBC00; bus.io_data = 8'hFF; bus.io_wr = 1'b1;
      @(posedge clk_sys); #1;
      chk("t7_lock_pulse", 8'(lp_a), 8'h01);
      chk("t7_status", st_a, 8'h00);
      plus_mode = 1'b1;
      @(posedge clk_sys); #1;
      bus.io_wr = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      chk("t7_status_after", st_a, 8'h00);
      chk("t7_lock_pulse_count", 8'(lp_cnt_a), 8'h01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gx4000_asic_lock.md
# gx4000_asic_lock

Parametrised Plus-ASIC lock/unlock detector for the GX4000/CPC+ core. It monitors CPU I/O writes to the CRTC select port. It implements the hardware synchronise-then-match protocol: a non-zero byte followed by `00`, then `SEQ_LEN` fixed bytes, then a key byte. On success it drives the `unlocked` enable consumed by the ASIC register page mapper. Unlike the previous fixed-sequence detector, it has:
- a configurable port decode,
- true resynchronisation,
- relock on a wrong key byte,
- event pulses and a position/status readout.

## Interface
Parameters:
- `SEQ_LEN`, 14: number of match bytes after the sync pair; legal range 1..30.
- `ADDR_MASK`, 16'h4300: I/O address bits compared.
- `ADDR_MATCH`, 16'h0000: required value of `io_addr & ADDR_MASK`. The default decodes CRTC select `&BCxx`.
- `ALLOW_RELOCK`, 1: 1 = a wrong key byte relocks; 0 = `unlocked` is sticky until reset.

Ports:
- `clk_sys`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `plus_mode`  in  1  Plus features enabled
- `io_addr`  in  16  CPU I/O address
- `io_data`  in  8  CPU I/O write data
- `io_wr`  in  1  I/O write strobe (level, may last several cycles)
- `unlocked`  out  1  ASIC registers accessible
- `unlock_pulse`  out  1  one-cycle pulse when `unlocked` goes 0→1
- `lock_pulse`  out  1  one-cycle pulse when `unlocked` goes 1→0 (relock or `plus_mode` drop)
- `seq_pos`  out  5  current match index (0 outside MATCH)
- `status`  out  8  {`unlocked`, state[1:0], `seq_pos`}

## Operation
- **Write accept:** a write is accepted when `io_wr & ~io_wr_q & ((io_addr & ADDR_MASK) == ADDR_MATCH)`.
  - Exactly one accept per strobe, however long `io_wr` is held.
  - `io_data` is sampled in the accept cycle.
- **FSM states:** HUNT, SYNC, MATCH, KEY. Transitions occur only on accepted writes.
  - HUNT: non-zero byte → SYNC; `00` → stay in HUNT.
  - SYNC: `00` → MATCH with `seq_pos`=0; non-zero → stay in SYNC.
  - MATCH: byte == `UNLOCK_SEQ[seq_pos]`:
    - if `seq_pos` == SEQ_LEN-1 → KEY;
    - otherwise `seq_pos`+1.
  - MATCH, mismatch: `00` → MATCH with `seq_pos`=0 (resync); non-zero → SYNC.
  - KEY: byte == `UNLOCK_KEY` sets `unlocked`=1. Any other byte clears `unlocked` when `ALLOW_RELOCK`=1, and leaves it unchanged otherwise. Next state is SYNC if the byte is non-zero, HUNT if it is `00`.
- `UNLOCK_SEQ` default (SEQ_LEN=14): FF 77 B3 51 A8 D4 62 39 9C 46 2B 15 8A CD. `UNLOCK_KEY` = EE. The full stream is therefore FF 00 FF 77 … CD EE.
- Writes to non-decoded ports are ignored; they neither advance nor break the sequence.
- **`plus_mode`=0:** FSM is forced to HUNT, `seq_pos`=0 and `unlocked`=0. If `unlocked` was 1, `lock_pulse` fires. Accepts are ignored.
- **Unlocked state:** the FSM keeps running, so a later full sequence with a wrong key relocks.
- **Pulses:** `unlock_pulse` fires only on a 0→1 change. A repeated correct key while already unlocked gives no pulse.

## Timing
- Reset values: state HUNT, `io_wr_q`=0, and every output 0 (`unlocked`, both pulses, `seq_pos`, `status`).
- All outputs are registered.
- An accept in cycle N updates state, `seq_pos` and `unlocked` at the edge ending cycle N, so the new values are visible in cycle N+1.
- Pulses are high for cycle N+1 only.
- `reset` has priority over everything and aborts mid-sequence with no pulse. `plus_mode`=0 has priority over an accept in the same cycle.
- No back-pressure exists; the minimum accept spacing is 2 cycles because of the edge detect.

## Structure
- `gx4000_pkg` holds: `UNLOCK_SEQ` (30-entry array, indices ≥ SEQ_LEN unused), `UNLOCK_KEY`, and the `lock_state_t` enum (HUNT=0, SYNC=1, MATCH=2, KEY=3). This package is shared with the register mapper and the bench.
- One sub-module: `gx4000_io_wr_decode`, which does the strobe edge detect plus the mask/match decode and outputs `wr_accept` and `wr_data`.

## Test plan
- FF 00 FF 77 B3 51 A8 D4 62 39 9C 46 2B 15 8A CD EE to `&BC00`, each write with a 3-cycle `io_wr` → `unlocked`=1 and `unlock_pulse`=1 one cycle after the EE accept, exactly one pulse, `status`[7]=1.
- Unlocked, then the full sequence ending in `00` instead of EE → `unlocked`=0 with `lock_pulse`. Repeat with `ALLOW_RELOCK`=0 → `unlocked` stays 1.
- Sequence broken at position 6 by `00`, followed by FF 77 … CD EE → unlocks (resync). Broken by `55` instead → `seq_pos`=0, state SYNC, no unlock until a new `00` arrives.
- Full sequence interleaved with writes to `&BD00` and `&7F00` → those writes are ignored and the unlock still occurs; the same sequence sent only to `&BD00` → no unlock.
- `reset` asserted after byte 10 → all outputs 0. A completing tail sent after reset does not unlock.
- Unlocked, `plus_mode` dropped → `lock_pulse`, `unlocked`=0; an accept in that same cycle is ignored.
